// File: rtl/wb_pkg.sv
// Shared Wishbone types: transfer width encoding and arbiter state.
package wb_pkg;

    localparam int unsigned WB_WIDTH_BITS = 2;

    typedef enum logic [WB_WIDTH_BITS-1:0] {
        eDW_B = 2'd0,
        eDW_H = 2'd1,
        eDW_W = 2'd2,
        eDW_D = 2'd3
    } eDataWidth;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } eArbState;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_last+1, wrapping.
module wb_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0]  w_start;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [31:0]    w_sum;

    always_comb begin
        w_start = (32'(i_last) >= N - 1) ? '0 : i_last + IW'(1);
        // Rotate so the preferred requester sits at bit 0, then take the lowest set bit.
        w_dbl   = {i_req, i_req} >> w_start;
        w_rot   = w_dbl[N-1:0];
        w_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IW'(i);
        end
        w_sum = 32'(w_start) + 32'(w_off);
        if (w_sum >= N) w_sum = w_sum - N;
        o_idx   = IW'(w_sum);
        o_valid = |i_req;
        o_grant = '0;
        if (o_valid) o_grant[o_idx] = 1'b1;
    end

endmodule

// File: rtl/wb_arbiter.sv
// N-master to one-slave Wishbone round-robin arbiter; grant held for the whole cyc.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned N_MASTERS      = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                              iClk,
    input  logic                              nRst,
    input  logic [N_MASTERS-1:0]              m_cyc,
    input  logic [N_MASTERS-1:0]              m_stb,
    input  logic [N_MASTERS-1:0]              m_we,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_data_write,
    input  logic [N_MASTERS*WB_WIDTH_BITS-1:0] m_width,
    output logic [N_MASTERS-1:0]              m_ack,
    output logic [N_MASTERS-1:0]              m_err,
    output logic [DATA_WIDTH-1:0]             m_data_read,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_data_write,
    output logic [WB_WIDTH_BITS-1:0]          s_width,
    input  logic                              s_ack,
    input  logic [DATA_WIDTH-1:0]             s_data_read,
    output logic [N_MASTERS-1:0]              oGrant
);

    localparam int unsigned IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    eArbState             r_state;
    logic [N_MASTERS-1:0] r_grant;
    logic [IW-1:0]        r_gidx;
    logic [IW-1:0]        r_last;

    logic [N_MASTERS-1:0] w_pick_grant;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_granted;
    logic                 w_tmo;
    logic                 w_release;

    wb_rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .i_req   (m_cyc),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_granted = (r_state == GRANT);
    assign w_release = w_granted && (!m_cyc[r_gidx] || w_tmo);
    assign oGrant    = r_grant;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;

    assign w_tmo = w_granted && (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_tmo_cnt <= '0;
        end else if (!w_granted || s_ack || w_release) begin
            r_tmo_cnt <= '0;
        end else if (m_stb[r_gidx]) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end
`else
    logic [31:0] w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= IW'(N_MASTERS - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= GRANT;
                        r_grant <= w_pick_grant;
                        r_gidx  <= w_pick_idx;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_last  <= r_gidx;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // A watchdog expiry drops the slave cycle in the same cycle the error is raised.
        s_cyc        = w_granted && !w_tmo && m_cyc[r_gidx];
        s_stb        = w_granted && !w_tmo && m_stb[r_gidx];
        s_we         = 1'b0;
        s_addr       = '0;
        s_data_write = '0;
        s_width      = WB_WIDTH_BITS'(eDW_B);
        if (w_granted) begin
            s_we         = m_we[r_gidx];
            s_addr       = m_addr[r_gidx*ADDR_WIDTH +: ADDR_WIDTH];
            s_data_write = m_data_write[r_gidx*DATA_WIDTH +: DATA_WIDTH];
            s_width      = m_width[r_gidx*WB_WIDTH_BITS +: WB_WIDTH_BITS];
        end
        m_ack = '0;
        m_err = '0;
        if (s_stb) m_ack[r_gidx] = s_ack;
        if (w_tmo) m_err[r_gidx] = 1'b1;
        m_data_read = s_data_read;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; timeout section active when WB_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 8;

    logic              iClk = 1'b0;
    logic              nRst;
    logic [N-1:0]      m_cyc, m_stb, m_we, m_ack, m_err;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_data_write;
    logic [N*2-1:0]    m_width;
    logic [DW-1:0]     m_data_read;
    logic              s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_data_write, s_data_read;
    logic [1:0]        s_width;
    logic [N-1:0]      oGrant;

    int n_checks = 0;
    int n_errors = 0;
    int g;

    wb_arbiter #(
        .N_MASTERS      (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .iClk         (iClk),
        .nRst         (nRst),
        .m_cyc        (m_cyc),
        .m_stb        (m_stb),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_data_write (m_data_write),
        .m_width      (m_width),
        .m_ack        (m_ack),
        .m_err        (m_err),
        .m_data_read  (m_data_read),
        .s_cyc        (s_cyc),
        .s_stb        (s_stb),
        .s_we         (s_we),
        .s_addr       (s_addr),
        .s_data_write (s_data_write),
        .s_width      (s_width),
        .s_ack        (s_ack),
        .s_data_read  (s_data_read),
        .oGrant       (oGrant)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc        = '0;
        m_stb        = '0;
        m_we         = '0;
        m_addr       = '0;
        m_data_write = '0;
        m_width      = '0;
        s_ack        = 1'b0;
        s_data_read  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRst = 1'b0;
        #1;
        nRst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        nRst = 1'b0;
        #12;
        chk("rst_grant", 64'(oGrant), 'h0);
        chk("rst_s_cyc", 64'(s_cyc), 'h0);
        chk("rst_s_stb", 64'(s_stb), 'h0);
        chk("rst_s_width", 64'(s_width), 64'(eDW_B));
        chk("rst_m_ack", 64'(m_ack), 'h0);
        chk("rst_m_err", 64'(m_err), 'h0);
        tick();
        nRst = 1'b1;

        // Single read from master 0, ack on the second strobe cycle
        tick();
        m_cyc = 4'b0001;
        m_stb = 4'b0001;
        m_addr[0 +: AW] = 32'h0000_0100;
        #1;
        chk("t1_same_cycle_s_cyc", 64'(s_cyc), 'h0);
        tick(); #1;
        chk("t1_grant", 64'(oGrant), 'h1);
        chk("t1_s_cyc", 64'(s_cyc), 'h1);
        chk("t1_no_ack_yet", 64'(m_ack), 'h0);
        tick();
        s_ack = 1'b1;
        s_data_read = 32'hDEAD_BEEF;
        #1;
        chk("t1_ack", 64'(m_ack), 'h1);
        chk("t1_rdata", 64'(m_data_read), 64'hDEAD_BEEF);
        tick();
        s_ack = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        #1;
        chk("t1_s_cyc_drop", 64'(s_cyc), 'h0);
        chk("t1_grant_held", 64'(oGrant), 'h1);
        tick(); #1;
        chk("t1_idle", 64'(oGrant), 'h0);

        // Round robin with all four masters requesting
        do_reset();
        m_cyc = 4'b1111;
        m_stb = 4'b1111;
        s_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            tick(); #1;
            chk($sformatf("rr%0d_grant", k), 64'(oGrant), 64'(1) << g);
            chk($sformatf("rr%0d_ack", k), 64'(m_ack), 64'(1) << g);
            tick();
            m_cyc[g] = 1'b0;
            m_stb[g] = 1'b0;
            #1;
            chk($sformatf("rr%0d_drop", k), 64'(s_cyc), 'h0);
            tick();
            m_cyc[g] = 1'b1;
            m_stb[g] = 1'b1;
            #1;
            chk($sformatf("rr%0d_idle", k), 64'(oGrant), 'h0);
        end
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;

        // Master 2 burst while master 1 waits
        m_cyc = 4'b0100;
        m_stb = 4'b0100;
        tick(); #1;
        chk("burst_grant", 64'(oGrant), 'h4);
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        s_ack = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk($sformatf("burst%0d_ack", b), 64'(m_ack), 'h4);
            chk($sformatf("burst%0d_grant", b), 64'(oGrant), 'h4);
            tick();
        end
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        s_ack = 1'b0;
        #1;
        chk("burst_end_s_cyc", 64'(s_cyc), 'h0);
        chk("burst_end_ack", 64'(m_ack), 'h0);
        tick(); #1;
        chk("burst_idle", 64'(oGrant), 'h0);
        tick(); #1;
        chk("burst_m1_grant", 64'(oGrant), 'h2);
        chk("burst_m1_s_cyc", 64'(s_cyc), 'h1);
        m_cyc = '0;
        m_stb = '0;
        tick();

        // Field passthrough under grant 3, with decoy fields on master 0
        m_addr[3*AW +: AW]       = 32'h1000_0004;
        m_data_write[3*DW +: DW] = 32'h0000_BEEF;
        m_width[3*2 +: 2]        = eDW_H;
        m_we[3]                  = 1'b1;
        m_addr[0 +: AW]          = 32'hAAAA_0000;
        m_data_write[0 +: DW]    = 32'h0000_1234;
        m_width[0 +: 2]          = eDW_W;
        m_cyc = 4'b1000;
        m_stb = 4'b1000;
        #1;
        chk("pt_idle_addr", 64'(s_addr), 'h0);
        tick(); #1;
        chk("pt_grant", 64'(oGrant), 'h8);
        chk("pt_addr", 64'(s_addr), 64'h1000_0004);
        chk("pt_we", 64'(s_we), 'h1);
        chk("pt_width", 64'(s_width), 64'(eDW_H));
        chk("pt_wdata", 64'(s_data_write), 64'h0000_BEEF);
        m_addr[3*AW +: AW] = 32'h1000_0008;
        #1;
        chk("pt_addr_follow", 64'(s_addr), 64'h1000_0008);
        m_stb[3] = 1'b0;
        s_ack = 1'b1;
        #1;
        chk("pt_ack_gated", 64'(m_ack), 'h0);
        chk("pt_stb_low", 64'(s_stb), 'h0);
        s_ack = 1'b0;

        // Asynchronous reset mid-burst
        m_cyc = 4'b1111;
        m_stb = 4'b1111;
        #1;
        chk("ar_s_cyc_before", 64'(s_cyc), 'h1);
        nRst = 1'b0;
        #1;
        chk("ar_s_cyc", 64'(s_cyc), 'h0);
        chk("ar_grant", 64'(oGrant), 'h0);
        chk("ar_s_addr", 64'(s_addr), 'h0);
        tick();
        nRst = 1'b1;
        tick(); #1;
        chk("ar_first_m0", 64'(oGrant), 'h1);
        m_cyc = '0;
        m_stb = '0;
        tick();

        // Stuck slave
        do_reset();
        m_cyc = 4'b0011;
        m_stb = 4'b0011;
        tick(); #1;
        chk("to_grant", 64'(oGrant), 'h1);
`ifdef WB_ARB_TIMEOUT_EN
        chk("to_err_c1", 64'(m_err), 'h0);
        for (int c = 2; c <= 8; c++) begin
            tick(); #1;
            chk($sformatf("to_err_c%0d", c), 64'(m_err), 'h0);
        end
        tick(); #1;
        chk("to_err_pulse", 64'(m_err), 'h1);
        chk("to_s_cyc", 64'(s_cyc), 'h0);
        chk("to_s_stb", 64'(s_stb), 'h0);
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        tick(); #1;
        chk("to_err_cleared", 64'(m_err), 'h0);
        chk("to_idle", 64'(oGrant), 'h0);
        tick(); #1;
        chk("to_next_grant", 64'(oGrant), 'h2);
`else
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("noto_err_c%0d", c), 64'(m_err), 'h0);
            tick(); #1;
        end
        chk("noto_grant_held", 64'(oGrant), 'h1);
        chk("noto_s_cyc", 64'(s_cyc), 'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
